// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between instruction fetch and data ports.
// Data wins by default; a saturating starvation count forces a fetch grant.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  mem_enable,
    output logic                  mem_write_enable,
    output logic [3:0]            mem_byte_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int unsigned CntWidth = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(STARVE_LIMIT);

    logic [CntWidth-1:0]   starve_cnt_q, starve_cnt_d;
    logic                  starved;
    logic                  grant_i, grant_d;
    logic                  i_rvalid_q, d_rvalid_q;
    logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

    always_comb begin
        starved = (starve_cnt_q == CntMax);
        grant_i = !reset && i_req && (!d_req || starved);
        grant_d = !reset && d_req && !grant_i;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_i) begin
            starve_cnt_d = '0;
        end else if (i_req && !starved) begin
            starve_cnt_d = starve_cnt_q + CntWidth'(1);
        end
    end

    always_comb begin
        mem_enable       = 1'b0;
        mem_write_enable = 1'b0;
        mem_byte_enable  = 4'h0;
        mem_address      = '0;
        mem_write_data   = '0;
        if (grant_i) begin
            mem_enable      = 1'b1;
            mem_byte_enable = 4'hF;
            mem_address     = i_addr;
        end else if (grant_d) begin
            mem_enable       = 1'b1;
            mem_write_enable = d_we;
            mem_byte_enable  = d_we ? d_be : 4'hF;
            mem_address      = d_addr;
            mem_write_data   = d_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            i_rvalid_q   <= grant_i;
            d_rvalid_q   <= grant_d;
            if (grant_i) begin
                i_rdata_q <= mem_read_data;
            end
            if (grant_d) begin
                d_rdata_q <= d_we ? '0 : mem_read_data;
            end
        end
    end

    // Responses are masked while reset is high so a pending response never escapes.
    assign i_gnt    = grant_i;
    assign d_gnt    = grant_d;
    assign i_rvalid = i_rvalid_q && !reset;
    assign d_rvalid = d_rvalid_q && !reset;
    assign i_rdata  = reset ? '0 : i_rdata_q;
    assign d_rdata  = reset ? '0 : d_rdata_q;

endmodule
